bip_run_ctrl_core: RTL and testbench
====================================

Name: bip_run_ctrl_core

Overview:
- Parametrised successor of the BIP accumulator machine.
- Contains the following in one block:
  - single-cycle fetch/execute;
  - internal program memory and data memory, both register arrays;
  - the accumulator;
  - a run-control FSM (IDLE/RUN/HALTED) with start, stop, resume and single-step.
- Adds to the original ISA:
  - conditional branch (BEQ) and unconditional jump (JMP);
  - a host program-load port;
  - a saturating retired-instruction counter.
- Sits at the SoC top level, driven by a host or debug controller.

Parameters:
ADDRESS_BITS, 11, operand/PC width; instruction = 5-bit opcode + ADDRESS_BITS operand.
DATA_BITS, 16, accumulator/data/instruction width; must equal ADDRESS_BITS+5.
PROG_DEPTH, 2048, program words implemented (<= 2^ADDRESS_BITS).
DATA_DEPTH, 1024, data words implemented (<= 2^ADDRESS_BITS).
CNT_BITS, 8, retired-instruction counter width.

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
i_start  in  1  pulse: clear PC/ACC/count/done, enter RUN
i_resume  in  1  pulse: IDLE->RUN, state preserved
i_stop  in  1  pulse: RUN->IDLE (pause)
i_step  in  1  pulse: execute one instruction while IDLE
i_prog_we  in  1  program-memory write enable
i_prog_addr  in  ADDRESS_BITS  program write address
i_prog_data  in  DATA_BITS  program write data
o_acc  out  DATA_BITS  accumulator
o_pc  out  ADDRESS_BITS  program counter
o_inst_count  out  CNT_BITS  retired non-HLT instructions, saturating
o_busy  out  1  state==RUN
o_done  out  1  HLT executed, held until next i_start

Behaviour:
- Reset (async, any time incl. mid-RUN):
  - State=IDLE; PC, ACC, count =0; o_busy=0, o_done=0.
  - Memory arrays are not reset.
- Opcodes (instr[DATA_BITS-1:ADDRESS_BITS]); op = operand field:
  - 00000 HLT
  - 00001 STO: mem[op]<=ACC
  - 00010 LD: ACC<=mem[op]
  - 00011 LDI: ACC<=sext(op)
  - 00100 ADD: ACC+=mem[op]
  - 00101 ADDI: ACC+=sext(op)
  - 00110 SUB: ACC-=mem[op]
  - 00111 SUBI: ACC-=sext(op)
  - 01000 BEQ: if ACC==0 PC<=op else PC+1
  - 01001 JMP: PC<=op
  - all others: NOP (PC+1, counted).
- Arithmetic:
  - Immediates are sign-extended from ADDRESS_BITS.
  - Add/sub wrap modulo 2^DATA_BITS; no flags.
- Memory reads:
  - Program and data reads are combinational.
  - Data writes are synchronous.
- Execution: one instruction per clock while executing; results visible on outputs the cycle after the edge.
- Address bounds:
  - PC increments modulo 2^ADDRESS_BITS.
  - Fetch at PC>=PROG_DEPTH returns 0 (HLT).
  - Data address >=DATA_DEPTH: reads return 0, writes dropped.
- HLT:
  - PC not advanced, count not incremented, ACC unchanged.
  - Next state HALTED, o_done<=1.
- FSM:
  - IDLE:
    - i_start -> RUN with PC/ACC/count/done cleared.
    - else i_resume -> RUN.
    - else i_step -> execute instruction at PC this cycle; stay IDLE (or HALTED if HLT).
  - RUN:
    - i_stop -> IDLE; the instruction in that cycle is NOT executed.
    - else execute; HLT -> HALTED.
    - i_start/i_resume/i_step ignored.
  - HALTED:
    - i_start -> RUN (cleared as above).
    - i_resume/i_step/i_stop ignored.
- Same-cycle input priority: start > resume > step (IDLE); stop is the only command honoured in RUN.
- Program load:
  - i_prog_we honoured only in IDLE or HALTED; ignored in RUN.
  - A write to an address >=PROG_DEPTH is dropped.
  - Write in the same cycle as i_step: the step fetches the old word.
- Counter: +1 per retired non-HLT instruction (run or step); holds at 2^CNT_BITS-1.
- o_done:
  - Set on HLT retirement.
  - Cleared only by i_start or rst.
  - o_busy=0 whenever o_done=1.

Test Plan:
1. Load LDI 5; ADDI 3; STO 2; SUBI 10; LD 2; HLT, pulse i_start -> o_done after 6 cycles; o_acc=0x0008, o_inst_count=5, mem[2]=0x0008, o_pc=5, o_busy=0.
2. Load LDI 0x7FF; ADDI 0x001; HLT, start -> ACC=0xFFFF after LDI, then 0x0000; count=2.
3. Load LDI 3; SUBI 1; BEQ 4; JMP 1; HLT, start -> done with o_acc=0, o_inst_count=9, o_pc=4.
4. Run test-1 program, pulse i_stop after 2 cycles -> IDLE, o_pc=2, o_acc=8. i_step -> o_pc=3, mem[2]=8. i_resume -> completes, identical to test 1. i_prog_we during RUN leaves memory unchanged.
5. CNT_BITS=4, program JMP 0; run 40 cycles -> o_inst_count holds 15, o_busy=1. i_stop -> IDLE.
6. Assert rst asynchronously mid-RUN of test 3 -> all outputs 0 immediately, without a clock edge. Program memory retained. Re-start reproduces test 3 results.

Source files
------------

// File: rtl/bip_run_ctrl_core.sv
// bip_run_ctrl_core: single-cycle BIP accumulator machine with internal
// program/data register arrays, BEQ/JMP, a host program-load port, a
// saturating retired-instruction counter and IDLE/RUN/HALTED run control.
module bip_run_ctrl_core #(
  parameter int ADDRESS_BITS = 11,
  parameter int DATA_BITS    = 16,
  parameter int PROG_DEPTH   = 2048,
  parameter int DATA_DEPTH   = 1024,
  parameter int CNT_BITS     = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start,
  input  logic                    i_resume,
  input  logic                    i_stop,
  input  logic                    i_step,
  input  logic                    i_prog_we,
  input  logic [ADDRESS_BITS-1:0] i_prog_addr,
  input  logic [DATA_BITS-1:0]    i_prog_data,
  output logic [DATA_BITS-1:0]    o_acc,
  output logic [ADDRESS_BITS-1:0] o_pc,
  output logic [CNT_BITS-1:0]     o_inst_count,
  output logic                    o_busy,
  output logic                    o_done
);

  // Index widths of the implemented arrays; addresses beyond the depth are
  // range-checked against the full operand so they never alias low words.
  localparam int PA_W = (PROG_DEPTH > 1) ? $clog2(PROG_DEPTH) : 1;
  localparam int DA_W = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;

  localparam logic [4:0] OP_HLT  = 5'b00000;
  localparam logic [4:0] OP_STO  = 5'b00001;
  localparam logic [4:0] OP_LD   = 5'b00010;
  localparam logic [4:0] OP_LDI  = 5'b00011;
  localparam logic [4:0] OP_ADD  = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SUBI = 5'b00111;
  localparam logic [4:0] OP_BEQ  = 5'b01000;
  localparam logic [4:0] OP_JMP  = 5'b01001;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t                         state, state_nxt;
  logic [ADDRESS_BITS-1:0]        pc, pc_nxt;
  logic signed [DATA_BITS-1:0]    acc, acc_nxt;
  logic [CNT_BITS-1:0]            cnt, cnt_nxt;
  logic                           done, done_nxt;

  logic [DATA_BITS-1:0]           prog_mem [PROG_DEPTH];
  logic signed [DATA_BITS-1:0]    data_mem [DATA_DEPTH];

  logic [DATA_BITS-1:0]           instr;
  logic [4:0]                     opcode;
  logic [ADDRESS_BITS-1:0]        operand;
  logic signed [DATA_BITS-1:0]    imm;
  logic signed [DATA_BITS-1:0]    mem_rd;
  logic                           data_in_range;
  logic                           exec;
  logic                           clear;
  logic                           dmem_we;
  logic                           prog_wr;

  function automatic logic signed [DATA_BITS-1:0] sext(input logic [ADDRESS_BITS-1:0] v);
    return {{(DATA_BITS-ADDRESS_BITS){v[ADDRESS_BITS-1]}}, v};
  endfunction

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
    return (&v) ? v : v + CNT_BITS'(1);
  endfunction

  // Combinational fetch/decode; words past the implemented depth read as HLT.
  always_comb begin
    instr         = (32'(pc) < PROG_DEPTH) ? prog_mem[pc[PA_W-1:0]] : '0;
    opcode        = instr[DATA_BITS-1 -: 5];
    operand       = instr[ADDRESS_BITS-1:0];
    imm           = sext(operand);
    data_in_range = (32'(operand) < DATA_DEPTH);
    mem_rd        = data_in_range ? data_mem[operand[DA_W-1:0]] : '0;
    prog_wr       = i_prog_we && (state != ST_RUN) && (32'(i_prog_addr) < PROG_DEPTH);
  end

  // Run-control next state: decides whether this cycle executes or clears.
  always_comb begin
    state_nxt = state;
    exec      = 1'b0;
    clear     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (i_start) begin
          clear     = 1'b1;
          state_nxt = ST_RUN;
        end else if (i_resume) begin
          state_nxt = ST_RUN;
        end else if (i_step) begin
          exec = 1'b1;
        end
      end
      ST_RUN: begin
        if (i_stop) state_nxt = ST_IDLE;
        else        exec      = 1'b1;
      end
      ST_HALTED: begin
        if (i_start) begin
          clear     = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (exec && (opcode == OP_HLT)) state_nxt = ST_HALTED;
  end

  // Execute: next PC/ACC/counter/done for the current instruction.
  always_comb begin
    pc_nxt   = pc;
    acc_nxt  = acc;
    cnt_nxt  = cnt;
    done_nxt = done;
    dmem_we  = 1'b0;
    if (clear) begin
      pc_nxt   = '0;
      acc_nxt  = '0;
      cnt_nxt  = '0;
      done_nxt = 1'b0;
    end else if (exec) begin
      pc_nxt  = pc + ADDRESS_BITS'(1);
      cnt_nxt = sat_inc(cnt);
      unique case (opcode)
        OP_HLT: begin
          pc_nxt   = pc;
          cnt_nxt  = cnt;
          done_nxt = 1'b1;
        end
        OP_STO:  dmem_we = 1'b1;
        OP_LD:   acc_nxt = mem_rd;
        OP_LDI:  acc_nxt = imm;
        OP_ADD:  acc_nxt = acc + mem_rd;
        OP_ADDI: acc_nxt = acc + imm;
        OP_SUB:  acc_nxt = acc - mem_rd;
        OP_SUBI: acc_nxt = acc - imm;
        OP_BEQ:  if (acc == '0) pc_nxt = operand;
        OP_JMP:  pc_nxt = operand;
        default: ;
      endcase
    end
  end

  // Architectural state register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      pc    <= '0;
      acc   <= '0;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      done  <= done_nxt;
    end
  end

  // Program memory host write port; blocked while running.
  always_ff @(posedge clk) begin
    if (prog_wr) prog_mem[i_prog_addr[PA_W-1:0]] <= i_prog_data;
  end

  // Data memory store; out-of-range addresses are dropped.
  always_ff @(posedge clk) begin
    if (dmem_we && data_in_range) data_mem[operand[DA_W-1:0]] <= acc;
  end

  assign o_acc        = acc;
  assign o_pc         = pc;
  assign o_inst_count = cnt;
  assign o_busy       = (state == ST_RUN);
  assign o_done       = done;

endmodule

// File: tb/tb_bip_run_ctrl_core.sv
// tb_bip_run_ctrl_core: directed programs checked against an instruction-level
// model of the machine every cycle, plus hand-computed end results.
module tb_bip_run_ctrl_core;

  localparam int AB = 11;
  localparam int DB = 16;
  localparam int PD = 64;
  localparam int DD = 32;
  localparam int CB = 4;
  localparam int CMAX = (1 << CB) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start = 1'b0, resume = 1'b0, stop = 1'b0, step = 1'b0;
  logic          we = 1'b0;
  logic [AB-1:0] waddr = '0;
  logic [DB-1:0] wdata = '0;
  logic [DB-1:0] acc;
  logic [AB-1:0] pc;
  logic [CB-1:0] cnt;
  logic          busy, done;

  int tests = 0;
  int fails = 0;

  bip_run_ctrl_core #(
    .ADDRESS_BITS(AB), .DATA_BITS(DB), .PROG_DEPTH(PD), .DATA_DEPTH(DD), .CNT_BITS(CB)
  ) dut (
    .clk(clk), .rst(rst), .i_start(start), .i_resume(resume), .i_stop(stop),
    .i_step(step), .i_prog_we(we), .i_prog_addr(waddr), .i_prog_data(wdata),
    .o_acc(acc), .o_pc(pc), .o_inst_count(cnt), .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: mode 0=idle 1=run 2=halted; whole-instruction semantics on ints.
  int m_mode = 0, m_pc = 0, m_acc = 0, m_cnt = 0, m_done = 0;
  int m_pmem [PD];
  int m_dmem [DD];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode <= 0; m_pc <= 0; m_acc <= 0; m_cnt <= 0; m_done <= 0;
    end else begin
      int l_mode, l_pc, l_acc, l_cnt, l_done, ins, opc, op, sop, rd;
      bit ex;
      l_mode = m_mode; l_pc = m_pc; l_acc = m_acc; l_cnt = m_cnt; l_done = m_done;
      ex = 0;
      if (m_mode == 0) begin
        if (start) begin l_mode = 1; l_pc = 0; l_acc = 0; l_cnt = 0; l_done = 0; end
        else if (resume) l_mode = 1;
        else if (step) ex = 1;
      end else if (m_mode == 1) begin
        if (stop) l_mode = 0; else ex = 1;
      end else if (start) begin
        l_mode = 1; l_pc = 0; l_acc = 0; l_cnt = 0; l_done = 0;
      end
      if (ex) begin
        ins = (m_pc < PD) ? m_pmem[m_pc] : 0;
        opc = ins / 2048;
        op  = ins % 2048;
        sop = (op >= 1024) ? op - 2048 : op;
        rd  = (op < DD) ? m_dmem[op] : 0;
        if (opc == 0) begin
          l_mode = 2; l_done = 1;
        end else begin
          l_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
          l_pc  = (m_pc + 1) % 2048;
          case (opc)
            1: if (op < DD) m_dmem[op] <= m_acc;
            2: l_acc = rd;
            3: l_acc = sop & 'hFFFF;
            4: l_acc = (m_acc + rd) & 'hFFFF;
            5: l_acc = (m_acc + sop) & 'hFFFF;
            6: l_acc = (m_acc - rd) & 'hFFFF;
            7: l_acc = (m_acc - sop) & 'hFFFF;
            8: if (m_acc == 0) l_pc = op;
            9: l_pc = op;
            default: ;
          endcase
        end
      end
      if (we && m_mode != 1 && waddr < PD) m_pmem[waddr] <= int'(wdata);
      m_mode <= l_mode; m_pc <= l_pc; m_acc <= l_acc; m_cnt <= l_cnt; m_done <= l_done;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      check("cyc_acc",  acc,  m_acc);
      check("cyc_pc",   pc,   m_pc);
      check("cyc_cnt",  cnt,  m_cnt);
      check("cyc_busy", busy, (m_mode == 1));
      check("cyc_done", done, m_done);
    end
  end

  function automatic logic [DB-1:0] ins(input int opc, input int op);
    return DB'((opc << 11) | (op & 'h7FF));
  endfunction

  task automatic put(input int a, input logic [DB-1:0] d);
    we = 1'b1; waddr = AB'(a); wdata = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  // 0=start 1=resume 2=stop 3=step, held for one rising edge
  task automatic pulse(input int c);
    case (c)
      0: start = 1'b1;
      1: resume = 1'b1;
      2: stop = 1'b1;
      default: step = 1'b1;
    endcase
    @(negedge clk);
    start = 1'b0; resume = 1'b0; stop = 1'b0; step = 1'b0;
  endtask

  task automatic wait_done(output int cyc, input int limit);
    cyc = 0;
    while (!done && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
    check("done_reached", done, 1);
  endtask

  task automatic load_t1();
    put(0, ins(3, 5)); put(1, ins(5, 3)); put(2, ins(1, 2));
    put(3, ins(7, 10)); put(4, ins(2, 2)); put(5, ins(0, 0));
  endtask

  task automatic load_t3();
    put(0, ins(3, 3)); put(1, ins(7, 1)); put(2, ins(8, 4));
    put(3, ins(9, 1)); put(4, ins(0, 0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_acc", acc, 0); check("rst_pc", pc, 0); check("rst_cnt", cnt, 0);
    check("rst_busy", busy, 0); check("rst_done", done, 0);
    rst = 1'b0;
    @(negedge clk);

    // Basic program
    load_t1();
    pulse(0);
    wait_done(cyc, 50);
    check("t1_cycles", cyc, 6);
    check("t1_acc", acc, 16'h0008); check("t1_cnt", cnt, 5);
    check("t1_pc", pc, 5); check("t1_busy", busy, 0);
    check("t1_mem2", {16'h0, dut.data_mem[2]}, 8);

    // Sign extension and wrap
    put(0, ins(3, 'h7FF)); put(1, ins(5, 1)); put(2, ins(0, 0));
    pulse(0);
    @(negedge clk);
    check("t2_acc_ldi", acc, 16'hFFFF);
    wait_done(cyc, 50);
    check("t2_acc", acc, 0); check("t2_cnt", cnt, 2); check("t2_pc", pc, 2);

    // Branch loop
    load_t3();
    pulse(0);
    wait_done(cyc, 100);
    check("t3_cycles", cyc, 10);
    check("t3_acc", acc, 0); check("t3_cnt", cnt, 9); check("t3_pc", pc, 4);

    // Zero mem[2] so the step below has a visible effect
    put(0, ins(3, 0)); put(1, ins(1, 2)); put(2, ins(0, 0));
    pulse(0);
    wait_done(cyc, 50);
    check("clr_mem2", {16'h0, dut.data_mem[2]}, 0);

    // Stop / step / resume, and load ignored during RUN
    load_t1();
    pulse(0);
    repeat (2) @(negedge clk);
    pulse(2);
    check("t4_pc_stop", pc, 2); check("t4_acc_stop", acc, 8);
    check("t4_busy_stop", busy, 0); check("t4_cnt_stop", cnt, 2);
    pulse(3);
    check("t4_pc_step", pc, 3); check("t4_mem2_step", {16'h0, dut.data_mem[2]}, 8);
    check("t4_cnt_step", cnt, 3);
    pulse(1);
    put(0, ins(3, 'h7FF));
    wait_done(cyc, 50);
    check("t4_acc", acc, 8); check("t4_cnt", cnt, 5); check("t4_pc", pc, 5);
    check("t4_prog0_kept", dut.prog_mem[0], ins(3, 5));

    // Address bounds: data alias, program write alias, fetch past depth
    put(0, ins(3, 7)); put(1, ins(1, 34)); put(2, ins(2, 34)); put(3, ins(9, 100));
    put(64, ins(3, 'h123));
    check("bnd_prog0", dut.prog_mem[0], ins(3, 7));
    pulse(0);
    wait_done(cyc, 50);
    check("bnd_acc", acc, 0); check("bnd_cnt", cnt, 4); check("bnd_pc", pc, 100);
    check("bnd_mem2", {16'h0, dut.data_mem[2]}, 8);

    // HALTED ignores resume/step/stop
    pulse(1); pulse(3); pulse(2);
    check("hlt_busy", busy, 0); check("hlt_done", done, 1); check("hlt_pc", pc, 100);

    // Step fetches the old word when written in the same cycle
    pulse(0);
    pulse(2);
    step = 1'b1; we = 1'b1; waddr = '0; wdata = ins(3, 9);
    @(negedge clk);
    step = 1'b0; we = 1'b0;
    check("stepwr_acc", acc, 7); check("stepwr_pc", pc, 1);
    check("stepwr_prog0", dut.prog_mem[0], ins(3, 9));

    // IDLE priority: start over resume/step, then resume over step
    start = 1'b1; resume = 1'b1; step = 1'b1;
    @(negedge clk);
    start = 1'b0; resume = 1'b0; step = 1'b0;
    check("pri_pc", pc, 0); check("pri_acc", acc, 0); check("pri_busy", busy, 1);
    pulse(2);
    resume = 1'b1; step = 1'b1;
    @(negedge clk);
    resume = 1'b0; step = 1'b0;
    check("pri2_pc", pc, 0); check("pri2_busy", busy, 1);
    wait_done(cyc, 50);
    check("pri2_acc", acc, 0); check("pri2_pc_end", pc, 100);

    // Counter saturation with tight loop; start ignored in RUN
    put(0, ins(9, 0));
    pulse(0);
    repeat (40) @(negedge clk);
    check("t5_cnt", cnt, 15); check("t5_busy", busy, 1); check("t5_done", done, 0);
    pulse(0);
    check("t5_cnt_start_ignored", cnt, 15);
    pulse(2);
    check("t5_busy_stop", busy, 0); check("t5_cnt_stop", cnt, 15);

    // Asynchronous reset mid-run
    load_t3();
    pulse(0);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t6_acc", acc, 0); check("t6_pc", pc, 0); check("t6_cnt", cnt, 0);
    check("t6_busy", busy, 0); check("t6_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    pulse(0);
    wait_done(cyc, 100);
    check("t6_re_acc", acc, 0); check("t6_re_cnt", cnt, 9); check("t6_re_pc", pc, 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
